// File: rtl/fifo_mc_pkg.sv
// Shared helpers for the multi-channel FIFO: derived widths and usedw bus slicing.
package fifo_mc_pkg;

  localparam int USEDW_BUS_MAX = 512;

  function automatic int chanWidth(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int usedwWidth(input int awidth);
    return awidth + 1;
  endfunction

  // Extracts channel ch's fill level from a (zero-extended) usedw bus.
  function automatic int usedwSlice(input logic [USEDW_BUS_MAX-1:0] bus, input int ch,
                                    input int awidth);
    logic [USEDW_BUS_MAX-1:0] shifted;
    int result;
    shifted = bus >> (ch * (awidth + 1));
    result  = 0;
    for (int b = 0; b <= awidth; b++) result[b] = shifted[b];
    return result;
  endfunction

endpackage

// File: rtl/fifo_mc_ram.sv
// Simple dual-port storage shared by all channels: one write port, one registered read port.
module fifo_mc_ram #(
  parameter int DWIDTH = 8,
  parameter int ABITS  = 6,
  parameter int DEPTH  = 64
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_we,
  input  logic [ABITS-1:0]  i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ABITS-1:0]  i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is cleared; it holds its value between reads.
  always_ff @(posedge i_clk) begin
    if (i_srst)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_mc.sv
// Multi-channel FIFO over one statically partitioned dual-port memory.
// Optional sticky overflow/underflow flags: define FIFO_MC_ERR_FLAGS_EN.
module fifo_mc
  import fifo_mc_pkg::*;
#(
  parameter int DWIDTH             = 8,
  parameter int AWIDTH             = 4,
  parameter int CHANNELS           = 4,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 2,
  localparam int CHW = chanWidth(CHANNELS),
  localparam int UW  = usedwWidth(AWIDTH)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [DWIDTH-1:0]      data_i,
  input  logic                   wrreq_i,
  input  logic [CHW-1:0]         wr_ch_i,
  input  logic                   rdreq_i,
  input  logic [CHW-1:0]         rd_ch_i,
  output logic [DWIDTH-1:0]      q_o,
  output logic                   rd_valid_o,
  output logic [CHANNELS-1:0]    empty_o,
  output logic [CHANNELS-1:0]    full_o,
  output logic [CHANNELS*UW-1:0] usedw_o,
  output logic [CHANNELS-1:0]    almost_full_o,
  output logic [CHANNELS-1:0]    almost_empty_o,
  output logic [CHANNELS-1:0]    ovf_o,
  output logic [CHANNELS-1:0]    udf_o
);

  localparam logic [UW-1:0] FULL_LVL = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [UW-1:0] AF_LVL   = UW'(ALMOST_FULL_VALUE);
  localparam logic [UW-1:0] AE_LVL   = UW'(ALMOST_EMPTY_VALUE);

  logic [UW-1:0]         r_wrPtr [CHANNELS];
  logic [UW-1:0]         r_rdPtr [CHANNELS];
  logic [UW-1:0]         w_usedw [CHANNELS];
  logic [CHANNELS-1:0]   w_wrHit;
  logic [CHANNELS-1:0]   w_rdHit;
  logic [CHW+AWIDTH-1:0] w_wrAddr;
  logic [CHW+AWIDTH-1:0] w_rdAddr;
  logic                  w_wrAcc;
  logic                  w_rdAcc;
  logic                  r_rdValid;

  // Flags come from the registered pointers, so acceptance never sees a same-cycle update.
  always_comb begin
    empty_o        = '0;
    full_o         = '0;
    almost_full_o  = '0;
    almost_empty_o = '0;
    usedw_o        = '0;
    w_wrHit        = '0;
    w_rdHit        = '0;
    w_wrAddr       = '0;
    w_rdAddr       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_usedw[c]               = r_wrPtr[c] - r_rdPtr[c];
      empty_o[c]               = (w_usedw[c] == '0);
      full_o[c]                = (w_usedw[c] == FULL_LVL);
      almost_full_o[c]         = (w_usedw[c] >= AF_LVL);
      almost_empty_o[c]        = (w_usedw[c] < AE_LVL);
      usedw_o[c*UW +: UW]      = w_usedw[c];
      if (!srst_i && wrreq_i && (wr_ch_i == CHW'(c))) begin
        w_wrHit[c] = ~full_o[c];
        w_wrAddr   = {CHW'(c), r_wrPtr[c][AWIDTH-1:0]};
      end
      if (!srst_i && rdreq_i && (rd_ch_i == CHW'(c))) begin
        w_rdHit[c] = ~empty_o[c];
        w_rdAddr   = {CHW'(c), r_rdPtr[c][AWIDTH-1:0]};
      end
    end
  end

  assign w_wrAcc = |w_wrHit;
  assign w_rdAcc = |w_rdHit;

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (srst_i) begin
        r_wrPtr[c] <= '0;
        r_rdPtr[c] <= '0;
      end else begin
        if (w_wrHit[c]) r_wrPtr[c] <= r_wrPtr[c] + UW'(1);
        if (w_rdHit[c]) r_rdPtr[c] <= r_rdPtr[c] + UW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) r_rdValid <= 1'b0;
    else        r_rdValid <= w_rdAcc;
  end

  // Gating with reset kills a valid pulse that would otherwise land inside a reset cycle.
  assign rd_valid_o = r_rdValid & ~srst_i;

  fifo_mc_ram #(
    .DWIDTH (DWIDTH),
    .ABITS  (CHW + AWIDTH),
    .DEPTH  (CHANNELS * (2 ** AWIDTH))
  ) u_ram (
    .i_clk   (clk_i),
    .i_srst  (srst_i),
    .i_we    (w_wrAcc),
    .i_waddr (w_wrAddr),
    .i_wdata (data_i),
    .i_re    (w_rdAcc),
    .i_raddr (w_rdAddr),
    .o_rdata (q_o)
  );

`ifdef FIFO_MC_ERR_FLAGS_EN
  logic [CHANNELS-1:0] w_ovfSet;
  logic [CHANNELS-1:0] w_udfSet;
  logic [CHANNELS-1:0] r_ovf;
  logic [CHANNELS-1:0] r_udf;

  always_comb begin
    w_ovfSet = '0;
    w_udfSet = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_ovfSet[c] = !srst_i && wrreq_i && (wr_ch_i == CHW'(c)) && full_o[c];
      w_udfSet[c] = !srst_i && rdreq_i && (rd_ch_i == CHW'(c)) && empty_o[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else begin
      r_ovf <= r_ovf | w_ovfSet;
      r_udf <= r_udf | w_udfSet;
    end
  end

  assign ovf_o = r_ovf;
  assign udf_o = r_udf;
`else
  assign ovf_o = '0;
  assign udf_o = '0;
`endif

endmodule

// File: tb/tb_fifo_mc.sv
// Scoreboard bench for fifo_mc: directed traffic feeds per-channel queues, a monitor checks reads.
module tb_fifo_mc;
  import fifo_mc_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int CH  = 4;
  localparam int CHW = chanWidth(CH);
  localparam int UW  = usedwWidth(AW);
`ifdef FIFO_MC_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             srst = 1'b1;
  logic [DW-1:0]    dataIn = '0;
  logic             wrreq = 1'b0;
  logic [CHW-1:0]   wrCh = '0;
  logic             rdreq = 1'b0;
  logic [CHW-1:0]   rdCh = '0;
  logic [DW-1:0]    q;
  logic             rdValid;
  logic [CH-1:0]    empty, full, almostFull, almostEmpty, ovf, udf;
  logic [CH*UW-1:0] usedw;

  exp_t          sbQ [$];
  logic [DW-1:0] modelQ [CH][$];
  exp_t          monEntry;
  int            cycleCnt = 0;
  int            checks = 0;
  int            failures = 0;

  fifo_mc dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (dataIn),
    .wrreq_i        (wrreq),
    .wr_ch_i        (wrCh),
    .rdreq_i        (rdreq),
    .rd_ch_i        (rdCh),
    .q_o            (q),
    .rd_valid_o     (rdValid),
    .empty_o        (empty),
    .full_o         (full),
    .usedw_o        (usedw),
    .almost_full_o  (almostFull),
    .almost_empty_o (almostEmpty),
    .ovf_o          (ovf),
    .udf_o          (udf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic int lvl(input int c);
    return usedwSlice(USEDW_BUS_MAX'(usedw), c, AW);
  endfunction

  // One bus cycle: drive inputs after the edge and let the reference queues decide acceptance.
  task automatic applyStimulus(input bit rst, input bit wr, input int wch, input logic [DW-1:0] wd,
                               input bit rd, input int rch);
    bit   wrOk, rdOk;
    exp_t e;
    @(posedge clk);
    #1;
    srst   = rst;
    wrreq  = wr;
    wrCh   = CHW'(wch);
    dataIn = wd;
    rdreq  = rd;
    rdCh   = CHW'(rch);
    if (rst) begin
      sbQ.delete();
      for (int c = 0; c < CH; c++) modelQ[c].delete();
    end else begin
      wrOk = wr && (modelQ[wch].size() < (1 << AW));
      rdOk = rd && (modelQ[rch].size() > 0);
      if (rdOk) begin
        e.data = modelQ[rch].pop_front();
        e.cyc  = cycleCnt + 1;
        sbQ.push_back(e);
      end
      if (wrOk) modelQ[wch].push_back(wd);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b0, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_empty"}, 32'(empty), 32'hF);
    checkOutput({tag, "_full"}, 32'(full), 0);
    checkOutput({tag, "_usedw"}, 32'(usedw), 0);
    checkOutput({tag, "_almostFull"}, 32'(almostFull), 0);
    checkOutput({tag, "_almostEmpty"}, 32'(almostEmpty), 32'hF);
    checkOutput({tag, "_rdValid"}, 32'(rdValid), 0);
    checkOutput({tag, "_q"}, 32'(q), 0);
    checkOutput({tag, "_ovf"}, 32'(ovf), 0);
    checkOutput({tag, "_udf"}, 32'(udf), 0);
  endtask

  // Monitor: every valid read must match the oldest expected word, in the cycle it was due.
  always @(negedge clk) begin
    if (rdValid) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedValid actual rd_valid=1 q=0x%0h expected rd_valid=0", q);
      end else begin
        monEntry = sbQ.pop_front();
        checkOutput("readData", 32'(q), 32'(monEntry.data));
        checkOutput("readLatency", cycleCnt, monEntry.cyc);
      end
    end else if (sbQ.size() > 0 && sbQ[0].cyc <= cycleCnt) begin
      monEntry = sbQ.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL missingValid actual rd_valid=0 expected data=0x%0h", monEntry.data);
    end
  end

  initial begin
    repeat (3) applyStimulus(1'b1, 1'b0, 0, 8'h00, 1'b0, 0);
    idle();
    checkResetState("reset");

    // Basic write/read on channel 1.
    applyStimulus(1'b0, 1'b1, 1, 8'hA1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1, 8'hA2, 1'b0, 0);
    idle();
    checkOutput("ch1Usedw", lvl(1), 2);
    checkOutput("ch1Empty", 32'(empty), 32'b1101);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b1, 1);
    idle();
    idle();
    checkOutput("ch1Drained", lvl(1), 0);

    // Fill channel 0 and overflow it.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 0, 8'(16 + i), 1'b0, 0);
      checkOutput("fillUsedw", lvl(0), i);
      checkOutput("fillAlmostFull", 32'(almostFull[0]), (i >= 12) ? 1 : 0);
      checkOutput("fillAlmostEmpty", 32'(almostEmpty[0]), (i < 2) ? 1 : 0);
    end
    idle();
    checkOutput("ch0Full", 32'(full), 32'b0001);
    checkOutput("ch0Usedw16", lvl(0), 16);
    applyStimulus(1'b0, 1'b1, 0, 8'hEE, 1'b0, 0);
    idle();
    checkOutput("ch0OvfUsedw", lvl(0), 16);
    checkOutput("ch0Ovf", 32'(ovf), ERR_EN ? 32'b0001 : 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b1, 0);
    idle();
    checkOutput("ch0Usedw12", lvl(0), 12);
    checkOutput("ch0AlmostFull12", 32'(almostFull[0]), 1);

    // Underflow on empty channel 3.
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b1, 3);
    idle();
    checkOutput("ch3Usedw", lvl(3), 0);
    checkOutput("ch3Empty", 32'(empty[3]), 1);
    checkOutput("ch3Udf", 32'(udf), ERR_EN ? 32'b1000 : 0);
    @(negedge clk);
    checkOutput("udfRdValid", 32'(rdValid), 0);

    // Concurrent write/read, same and different channels.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 2, 8'(32 + i), 1'b0, 0);
    idle();
    checkOutput("ch2Usedw5", lvl(2), 5);
    applyStimulus(1'b0, 1'b1, 2, 8'h25, 1'b1, 2);
    idle();
    checkOutput("ch2SameRW", lvl(2), 5);
    applyStimulus(1'b0, 1'b1, 0, 8'h30, 1'b1, 2);
    idle();
    checkOutput("crossCh0", lvl(0), 13);
    checkOutput("crossCh2", lvl(2), 4);

    // Streaming on channel 1 through several pointer wraps.
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1, 8'(64 + i), (i >= 3), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b1, 1);
    idle();
    checkOutput("wrapCh1", lvl(1), 0);
    checkOutput("wrapCh0", lvl(0), 13);
    checkOutput("wrapCh2", lvl(2), 4);
    checkOutput("wrapCh3", lvl(3), 0);
    checkOutput("wrapEmpty", 32'(empty), 32'b1010);
    checkOutput("wrapOvf", 32'(ovf), ERR_EN ? 32'b0001 : 0);
    checkOutput("wrapUdf", 32'(udf), ERR_EN ? 32'b1000 : 0);

    // Reset arriving while a read is in flight.
    applyStimulus(1'b0, 1'b1, 1, 8'h77, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 8'h00, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 0, 8'h00, 1'b0, 0);
    @(negedge clk);
    checkOutput("rstRdValid", 32'(rdValid), 0);
    applyStimulus(1'b1, 1'b0, 0, 8'h00, 1'b0, 0);
    @(negedge clk);
    checkOutput("rstRdValid2", 32'(rdValid), 0);
    idle();
    checkResetState("postRst");

    repeat (3) idle();
    checkOutput("sbDrained", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_mc.md
FIFO_MC -- requirements
Module: fifo_mc

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 4, per-channel depth 2**AWIDTH words.
REQ-003 The block SHALL have parameter CHANNELS, default 4, number of independent logical FIFOs (range 2..16); CHW = $clog2(CHANNELS).
REQ-004 The block SHALL have parameter ALMOST_FULL_VALUE, default 12, per-channel almost-full threshold.
REQ-005 The block SHALL have parameter ALMOST_EMPTY_VALUE, default 2, per-channel almost-empty threshold.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset, on the following ports:
- clk_i  in  1  clock, all logic on rising edge.
- srst_i  in  1  synchronous active-high reset.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- wr_ch_i  in  CHW  write channel select.
- rdreq_i  in  1  read request.
- rd_ch_i  in  CHW  read channel select.
- q_o  out  DWIDTH  read data.
- rd_valid_o  out  1  q_o holds data of an accepted read.
- empty_o  out  CHANNELS  per-channel empty.
- full_o  out  CHANNELS  per-channel full.
- usedw_o  out  CHANNELS*(AWIDTH+1)  per-channel fill level; channel c in bits [c*(AWIDTH+1) +: AWIDTH+1].
- almost_full_o  out  CHANNELS  usedw >= ALMOST_FULL_VALUE.
- almost_empty_o  out  CHANNELS  usedw < ALMOST_EMPTY_VALUE.
- ovf_o  out  CHANNELS  sticky overflow flag.
- udf_o  out  CHANNELS  sticky underflow flag.

Function
REQ-007 Each channel SHALL be a FIFO of 2**AWIDTH words in a statically partitioned region of one shared memory: address = {channel, pointer[AWIDTH-1:0]}.
REQ-008 Each channel SHALL keep AWIDTH+1-bit write/read pointers; usedw = wptr - rptr modulo 2**(AWIDTH+1); empty = usedw==0; full = usedw==2**AWIDTH; pointers wrap naturally.
REQ-009 A write SHALL be accepted when wrreq_i=1 and full_o[wr_ch_i]=0; the word is stored, that channel's wptr increments, and usedw/flags update at the next edge.
REQ-010 A read SHALL be accepted when rdreq_i=1 and empty_o[rd_ch_i]=0 (normal mode, not showahead); q_o SHALL present the word one cycle later with rd_valid_o=1 for exactly that cycle.
REQ-011 q_o SHALL hold its last value while rd_valid_o=0.
REQ-012 A word accepted at edge N SHALL be readable by a read request issued in cycle N+1 or later.
REQ-013 Simultaneous accepted write and read on the same channel SHALL leave that channel's usedw unchanged; on different channels each updates independently.
REQ-014 A write to a full channel SHALL be dropped with no state change except ovf; a read from an empty channel SHALL be dropped, give rd_valid_o=0, and set udf.
REQ-015 Full/empty acceptance SHALL use the registered flags of the current cycle, so a write to a full channel is dropped even with a same-cycle read on it.
REQ-016 Channels SHALL be fully independent; no operation on one channel alters another channel's pointers or flags.

Reset
REQ-017 While srst_i=1 all pointers SHALL clear, and requests SHALL be ignored.
REQ-018 Reset values SHALL be: empty_o all 1, full_o 0, usedw_o 0, almost_full_o 0, almost_empty_o all 1 (ALMOST_EMPTY_VALUE>0), rd_valid_o 0, q_o 0, ovf_o 0, udf_o 0.
REQ-019 Reset during an in-flight read SHALL suppress rd_valid_o in the following cycle; memory contents need not be cleared.

Configuration
REQ-020 With macro FIFO_MC_ERR_FLAGS_EN defined, ovf_o/udf_o SHALL set per REQ-014 and stay set until srst_i.
REQ-021 Without FIFO_MC_ERR_FLAGS_EN, ovf_o and udf_o SHALL be tied to 0 and no flag registers synthesised; all other behaviour is identical.

Structure
REQ-022 Package fifo_mc_pkg SHALL hold the CHW/usedw-width helper function and a usedw slice helper shared by RTL and bench.
REQ-023 Storage SHALL be one sub-module fifo_mc_ram: simple dual-port, DWIDTH x CHANNELS*2**AWIDTH, one write port, one registered read port.

Verification
REQ-024 Bench SHALL cover: after reset, write 0xA1,0xA2 to ch1 -> usedw[1]=2, empty_o=4'b1101; read ch1 twice -> q_o 0xA1 then 0xA2, each with rd_valid_o=1 one cycle after request.
REQ-025 Bench SHALL cover: fill ch0 with 16 words -> full_o[0]=1, almost_full_o[0]=1 from usedw=12; 17th write dropped, ovf_o[0]=1 (macro on) or 0 (macro off).
REQ-026 Bench SHALL cover: read empty ch3 -> rd_valid_o=0, udf_o[3]=1, no pointer change.
REQ-027 Bench SHALL cover: simultaneous write ch2 and read ch2 at usedw=5 -> usedw stays 5; write ch0 + read ch2 -> usedw[0]+1, usedw[2]-1.
REQ-028 Bench SHALL cover: 40 write/read cycles on ch1 (pointer wrap) -> data order preserved; ch0/ch2/ch3 untouched.
REQ-029 Bench SHALL cover: srst_i asserted the cycle after an accepted read -> rd_valid_o=0, all flags at reset values.
